pinaipple_gpio: RTL and testbench
=================================

// Module: pinaipple_gpio
// PURPOSE
//  Parametrised GPIO peripheral for pinaipple_system; replaces bare gp_i/gp_o wiring.
//  Inputs: 2-flop synchroniser, per-bit debounce, rise/fall edge detection.
//  Edges latch into sticky W1C status with per-bit interrupt enables.
//  Outputs: register with set/clear/toggle aliases; simple req/rvalid register bus.
// PARAMETERS
//  GPIWidth       8   number of inputs, 1..32
//  GPOWidth       8   number of outputs, 1..32
//  DebounceCycles 4   consecutive stable cycles before input accepted; 0 = bypass
//  GPOResetVal    '0  reset value of gp_o [GPOWidth-1:0]
// PORTS
//  clk_sys_in  in   1         system clock
//  rst_sys_in  in   1         async reset, active low
//  req_i       in   1         bus access request, single cycle
//  we_i        in   1         1 = write, 0 = read
//  addr_i      in   6         byte address; [1:0] ignored
//  wdata_i     in   32        write data
//  rvalid_o    out  1         response valid, cycle after req_i
//  rdata_o     out  32        read data, valid with rvalid_o; 0 for writes
//  err_o       out  1         unmapped address, valid with rvalid_o
//  gp_i        in   GPIWidth  asynchronous pin inputs
//  gp_o        out  GPOWidth  registered pin outputs
//  irq_o       out  1         level interrupt, registered
// BEHAVIOUR
//  Reset: gp_o=GPOResetVal; sync flops, debounced, counters, RISE/FALL status,
//   enables, rdata_o, rvalid_o, err_o, irq_o all 0. Async assert, sync release.
//  Map (RW unless noted; unused high bits read 0, write ignored):
//   0x00 GPO_VAL; 0x04 GPO_SET (W1S); 0x08 GPO_CLR (W1C); 0x0C GPO_TGL (W1T);
//   0x04-0x0C read as GPO_VAL. 0x10 GPI_VAL RO (debounced);
//   0x14 RISE_ST W1C; 0x18 FALL_ST W1C; 0x1C RISE_EN; 0x20 FALL_EN.
//   0x24-0x3C unmapped: read 0, write dropped, err_o=1.
//  Bus: one access per req_i cycle, back-to-back allowed.
//   Write takes effect on the edge sampling req_i.
//   rvalid_o pulses exactly 1 cycle later; read data sampled at req_i edge.
//  Sync: s = 2-flop(gp_i); s reflects pin 2 cycles after pin change.
//  Debounce, per bit, counter width $clog2(DebounceCycles+1):
//   s==deb: cnt<=0.
//   s!=deb, cnt<DebounceCycles-1: cnt++.
//   s!=deb, cnt==DebounceCycles-1: deb<=s, cnt<=0.
//   => deb follows s after DebounceCycles consecutive differing cycles;
//      pin->GPI_VAL latency = 2+DebounceCycles. Shorter glitches fully rejected.
//   DebounceCycles==0: deb<=s each cycle (latency 3).
//  Edge: deb 0->1 sets RISE_ST bit, 1->0 sets FALL_ST bit, on the edge deb flips.
//   Status is sticky; W1C clears. Same-cycle set and W1C on one bit: set wins.
//  Inputs high at reset release produce a rise edge (deb resets to 0).
//  irq_o <= |(RISE_ST&RISE_EN | FALL_ST&FALL_EN): 1 cycle after status/enable change.
//  Disabling an enable drops irq_o next cycle; status is kept.
//  Reset mid-debounce discards the in-flight count and any pending edge.
// TESTING
//  T1 GPOResetVal=0xA5, pulse reset -> gp_o=0xA5, irq_o=0, rvalid_o=0, RISE_ST=0.
//  T2 Wr GPO_VAL=0x30, GPO_SET 0x0F, GPO_CLR 0x21, GPO_TGL 0x81 -> gp_o 0x30,0x3F,0x1E,0x9F;
//     each read of 0x00 gives rvalid_o next cycle with matching data.
//  T3 Debounce=4: gp_i[0] high 3 cycles then low -> GPI_VAL=0, RISE_ST=0;
//     held high -> GPI_VAL[0]=1 and RISE_ST[0]=1 exactly 6 cycles after pin edge.
//  T4 RISE_EN=0x1, rise on bit0 -> irq_o=1 one cycle after RISE_ST;
//     W1C 0x1 -> irq_o=0 one cycle later; W1C same cycle as new rise -> RISE_ST[0] stays 1.
//  T5 Read 0x28 -> rvalid_o=1, err_o=1, rdata_o=0; write 0x3C -> no register changes.
//  T6 gp_i[3] high, reset asserted after 3 cycles, pin low before release ->
//     GPI_VAL=0, FALL_ST=RISE_ST=0, irq_o=0.

Source files
------------

// File: rtl/pinaipple_gpio.sv
// GPIO peripheral: synchronised and debounced inputs with sticky edge status and an interrupt, plus set/clear/toggle outputs.
// Bus response arrives 1 cycle after req_i. There is no backpressure: every req_i cycle is accepted.
module pinaipple_gpio #(
  parameter int unsigned          GPIWidth       = 8,
  parameter int unsigned          GPOWidth       = 8,
  parameter int unsigned          DebounceCycles = 4,
  parameter logic [GPOWidth-1:0]  GPOResetVal    = '0
) (
  input  logic                clk_sys_in,
  input  logic                rst_sys_in,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [5:0]          addr_i,
  input  logic [31:0]         wdata_i,
  output logic                rvalid_o,
  output logic [31:0]         rdata_o,
  output logic                err_o,
  input  logic [GPIWidth-1:0] gp_i,
  output logic [GPOWidth-1:0] gp_o,
  output logic                irq_o
);

  localparam int unsigned CntW = (DebounceCycles > 0) ? $clog2(DebounceCycles + 1) : 1;

  // Reset asserts asynchronously and is released two clock edges after rst_sys_in rises.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) rst_pipe <= '0;
    else             rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [GPIWidth-1:0] sync_q1, sync_q2;
  logic [GPIWidth-1:0] deb, deb_next;

  always_ff @(posedge clk_sys_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      deb     <= '0;
    end else begin
      sync_q1 <= gp_i;
      sync_q2 <= sync_q1;
      deb     <= deb_next;
    end
  end

  generate
    if (DebounceCycles == 0) begin : g_bypass
      assign deb_next = sync_q2;
    end else begin : g_debounce
      localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
      for (genvar i = 0; i < int'(GPIWidth); i++) begin : g_bit
        logic [CntW-1:0] cnt;
        logic            differ;
        assign differ      = sync_q2[i] != deb[i];
        assign deb_next[i] = (differ && cnt == CntLast) ? sync_q2[i] : deb[i];
        always_ff @(posedge clk_sys_in or negedge rst_n) begin
          if (!rst_n)                      cnt <= '0;
          else if (!differ || cnt == CntLast) cnt <= '0;
          else                             cnt <= cnt + CntW'(1);
        end
      end
    end
  endgenerate

  logic [GPIWidth-1:0] rise, fall;
  assign rise = deb_next & ~deb;
  assign fall = deb & ~deb_next;

  // Register bus decode: word index from addr_i[5:2].
  logic [3:0]          idx;
  logic                wr;
  logic                rd;
  logic [GPOWidth-1:0] wr_gpo;
  logic [GPIWidth-1:0] wr_gpi;
  logic                unused_bits;

  assign idx         = addr_i[5:2];
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign wr_gpo      = wdata_i[GPOWidth-1:0];
  assign wr_gpi      = wdata_i[GPIWidth-1:0];
  assign unused_bits = ^{addr_i[1:0], wdata_i};

  logic [GPOWidth-1:0] gpo;
  logic [GPIWidth-1:0] rise_st, fall_st, rise_en, fall_en;
  logic [GPIWidth-1:0] rise_clr, fall_clr;

  assign rise_clr = (wr && idx == 4'd5) ? wr_gpi : '0;
  assign fall_clr = (wr && idx == 4'd6) ? wr_gpi : '0;

  always_ff @(posedge clk_sys_in or negedge rst_n) begin
    if (!rst_n) begin
      gpo <= GPOResetVal;
    end else if (wr) begin
      case (idx)
        4'd0:    gpo <= wr_gpo;
        4'd1:    gpo <= gpo | wr_gpo;
        4'd2:    gpo <= gpo & ~wr_gpo;
        4'd3:    gpo <= gpo ^ wr_gpo;
        default: gpo <= gpo;
      endcase
    end
  end
  assign gp_o = gpo;

  // A new edge in the same cycle as a W1C keeps the status bit set.
  always_ff @(posedge clk_sys_in or negedge rst_n) begin
    if (!rst_n) begin
      rise_st <= '0;
      fall_st <= '0;
      rise_en <= '0;
      fall_en <= '0;
      irq_o   <= 1'b0;
    end else begin
      rise_st <= (rise_st & ~rise_clr) | rise;
      fall_st <= (fall_st & ~fall_clr) | fall;
      if (wr && idx == 4'd7) rise_en <= wr_gpi;
      if (wr && idx == 4'd8) fall_en <= wr_gpi;
      irq_o   <= |((rise_st & rise_en) | (fall_st & fall_en));
    end
  end

  logic [31:0] rd_mux;
  logic        mapped;

  always_comb begin
    rd_mux = '0;
    mapped = 1'b1;
    case (idx)
      4'd0, 4'd1, 4'd2, 4'd3: rd_mux = 32'(gpo);
      4'd4:    rd_mux = 32'(deb);
      4'd5:    rd_mux = 32'(rise_st);
      4'd6:    rd_mux = 32'(fall_st);
      4'd7:    rd_mux = 32'(rise_en);
      4'd8:    rd_mux = 32'(fall_en);
      default: mapped = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys_in or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= req_i;
      err_o    <= req_i & ~mapped;
      rdata_o  <= (rd && mapped) ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_pinaipple_gpio.sv
// Directed bench for pinaipple_gpio: a register vector table plus hand-timed debounce, interrupt and reset sequences.
module tb_pinaipple_gpio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [7:0]  gp_in = '0;
  logic [7:0]  gp_out;
  logic        irq;

  pinaipple_gpio #(
    .GPIWidth(8), .GPOWidth(8), .DebounceCycles(4), .GPOResetVal(8'hA5)
  ) dut (
    .clk_sys_in(clk), .rst_sys_in(rst_n),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .gp_i(gp_in), .gp_o(gp_out), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One bus access launched at a negedge; the response is captured at the following negedge.
  task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic v, output logic e);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    v = rvalid; rd = rdata; e = err;
  endtask

  task automatic wr_reg(input string name, input logic [5:0] a, input logic [31:0] d);
    logic [31:0] r; logic v, e;
    bus(1'b1, a, d, r, v, e);
    chk({name, " rvalid"}, 32'(v), 32'd1);
    chk({name, " err"}, 32'(e), 32'd0);
  endtask

  task automatic rd_reg(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] r; logic v, e;
    bus(1'b0, a, 32'd0, r, v, e);
    chk({name, " rvalid"}, 32'(v), 32'd1);
    chk({name, " err"}, 32'(e), 32'd0);
    chk(name, r, exp);
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] pins);
    rst_n = 1'b0;
    gp_in = pins;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(3);
  endtask

  typedef struct {
    logic        w;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_gpo;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r; logic v, e;

    vecs[0]  = '{1'b1, 6'h00, 32'h0000_0030, 32'h0, 1'b0, 8'h30};
    vecs[1]  = '{1'b0, 6'h00, 32'h0,         32'h30, 1'b0, 8'h30};
    vecs[2]  = '{1'b1, 6'h04, 32'h0000_000F, 32'h0, 1'b0, 8'h3F};
    vecs[3]  = '{1'b0, 6'h00, 32'h0,         32'h3F, 1'b0, 8'h3F};
    vecs[4]  = '{1'b1, 6'h08, 32'h0000_0021, 32'h0, 1'b0, 8'h1E};
    vecs[5]  = '{1'b0, 6'h00, 32'h0,         32'h1E, 1'b0, 8'h1E};
    vecs[6]  = '{1'b1, 6'h0C, 32'h0000_0081, 32'h0, 1'b0, 8'h9F};
    vecs[7]  = '{1'b0, 6'h00, 32'h0,         32'h9F, 1'b0, 8'h9F};
    vecs[8]  = '{1'b0, 6'h08, 32'h0,         32'h9F, 1'b0, 8'h9F};
    vecs[9]  = '{1'b0, 6'h0E, 32'h0,         32'h9F, 1'b0, 8'h9F};
    vecs[10] = '{1'b0, 6'h28, 32'h0,         32'h0,  1'b1, 8'h9F};
    vecs[11] = '{1'b1, 6'h3C, 32'hFFFF_FFFF, 32'h0,  1'b1, 8'h9F};
    vecs[12] = '{1'b1, 6'h24, 32'h0000_00FF, 32'h0,  1'b1, 8'h9F};
    vecs[13] = '{1'b0, 6'h1C, 32'h0,         32'h0,  1'b0, 8'h9F};
    vecs[14] = '{1'b1, 6'h00, 32'hFFFF_FF55, 32'h0,  1'b0, 8'h55};
    vecs[15] = '{1'b0, 6'h00, 32'h0,         32'h55, 1'b0, 8'h55};

    // Reset state
    @(negedge clk);
    do_reset(8'h00);
    chk("reset gp_o", 32'(gp_out), 32'hA5);
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset rvalid", 32'(rvalid), 32'd0);
    rd_reg("reset RISE_ST", 6'h14, 32'h0);
    @(negedge clk);
    chk("idle rvalid", 32'(rvalid), 32'd0);

    // Output aliases, unmapped accesses, address/data masking
    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].w, vecs[i].a, vecs[i].d, r, v, e);
      chk($sformatf("vec%0d rvalid", i), 32'(v), 32'd1);
      chk($sformatf("vec%0d rdata", i), r, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d gp_o", i), 32'(gp_out), 32'(vecs[i].exp_gpo));
    end
    rd_reg("after unmapped FALL_EN", 6'h20, 32'h0);

    // Glitch of 3 stable cycles is rejected
    gp_in = 8'h01;
    wait_neg(3);
    gp_in = 8'h00;
    wait_neg(10);
    rd_reg("glitch GPI_VAL", 6'h10, 32'h0);
    rd_reg("glitch RISE_ST", 6'h14, 32'h0);

    // Held level accepted exactly 6 cycles after the pin edge
    gp_in = 8'h01;
    wait_neg(5);
    rd_reg("GPI_VAL at edge 6", 6'h10, 32'h0);
    rd_reg("GPI_VAL at edge 7", 6'h10, 32'h1);
    rd_reg("rise RISE_ST", 6'h14, 32'h1);

    // Interrupt from rise status and enable
    wr_reg("clr RISE_ST", 6'h14, 32'h1);
    rd_reg("cleared RISE_ST", 6'h14, 32'h0);
    wr_reg("RISE_EN", 6'h1C, 32'h1);
    chk("irq idle with enable", 32'(irq), 32'd0);
    gp_in = 8'h00;
    wait_neg(10);
    rd_reg("fall FALL_ST", 6'h18, 32'h1);
    chk("irq fall not enabled", 32'(irq), 32'd0);
    gp_in = 8'h01;
    wait_neg(6);
    chk("irq before status", 32'(irq), 32'd0);
    wait_neg(1);
    chk("irq after status", 32'(irq), 32'd1);
    rd_reg("irq RISE_ST", 6'h14, 32'h1);
    wr_reg("disable RISE_EN", 6'h1C, 32'h0);
    chk("irq same cycle as disable", 32'(irq), 32'd1);
    wait_neg(1);
    chk("irq after disable", 32'(irq), 32'd0);
    rd_reg("status kept", 6'h14, 32'h1);
    wr_reg("enable RISE_EN", 6'h1C, 32'h1);
    chk("irq same cycle as enable", 32'(irq), 32'd0);
    wait_neg(1);
    chk("irq after enable", 32'(irq), 32'd1);
    wr_reg("W1C RISE_ST", 6'h14, 32'h1);
    chk("irq same cycle as W1C", 32'(irq), 32'd1);
    wait_neg(1);
    chk("irq after W1C", 32'(irq), 32'd0);

    // W1C landing on the same edge as a new rise: the set wins
    gp_in = 8'h00;
    wait_neg(10);
    gp_in = 8'h01;
    wait_neg(5);
    wr_reg("W1C on rise edge", 6'h14, 32'h1);
    rd_reg("set wins RISE_ST", 6'h14, 32'h1);
    wr_reg("clr FALL_ST", 6'h18, 32'h1);
    rd_reg("cleared FALL_ST", 6'h18, 32'h0);

    // Reset mid-debounce discards the pending edge
    gp_in = 8'h08;
    wait_neg(3);
    rst_n = 1'b0;
    wait_neg(1);
    gp_in = 8'h00;
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(12);
    chk("mid-reset irq", 32'(irq), 32'd0);
    chk("mid-reset gp_o", 32'(gp_out), 32'hA5);
    rd_reg("mid-reset GPI_VAL", 6'h10, 32'h0);
    rd_reg("mid-reset RISE_ST", 6'h14, 32'h0);
    rd_reg("mid-reset FALL_ST", 6'h18, 32'h0);
    rd_reg("mid-reset RISE_EN", 6'h1C, 32'h0);

    // Pin high through reset release yields a rise
    do_reset(8'h02);
    wait_neg(10);
    rd_reg("high at release GPI_VAL", 6'h10, 32'h2);
    rd_reg("high at release RISE_ST", 6'h14, 32'h2);
    rd_reg("high at release FALL_ST", 6'h18, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
